// File: rtl/mac_stg5_pkg.sv
// Shared float-format constants and the FIFO entry layout for the final MAC stage.
package mac_stg5_pkg;

  localparam int FP_EXP_W   = 6;
  localparam int FP_MAN_W   = 9;
  localparam int FP_EXP_SAT = 62;
  localparam int NORM_W     = 11;
  localparam int EXP_DIFF_W = 5;
  localparam int Q_W        = 5;
  localparam int FP_W       = 1 + FP_EXP_W + FP_MAN_W;

  localparam logic [FP_EXP_W-1:0] EXP_SAT_VAL = FP_EXP_W'(FP_EXP_SAT);
  localparam logic [FP_MAN_W-1:0] MAN_ALL_ONE = '1;

  typedef struct packed {
    logic [FP_W-1:0] data;
    logic [Q_W-1:0]  q_frac;
  } fifo_entry_t;

endpackage

// File: rtl/mac_stg5_fp_pack_rne.sv
// Combinational packer: exponent adjust, round-to-nearest-even on one guard bit,
// then zero / flush / saturate handling into the 16-bit float word.
module fp_pack_rne
  import mac_stg5_pkg::*;
(
  input  logic [NORM_W-1:0]     i_norm_sum,
  input  logic [EXP_DIFF_W-1:0] i_exp_diff,
  input  logic                  i_exp_carry,
  input  logic                  i_sgn,
  input  logic [FP_EXP_W-1:0]   i_max_exp,
  output logic [FP_W-1:0]       o_word
);

  logic signed [7:0]     exp_pre;
  logic signed [7:0]     exp_post;
  logic [FP_MAN_W-1:0]   man_pre;
  logic [FP_MAN_W-1:0]   man_post;
  logic                  round_up;
  logic                  man_ovf;

  assign exp_pre  = $signed({2'b00, i_max_exp})
                  + $signed({{3{i_exp_diff[EXP_DIFF_W-1]}}, i_exp_diff})
                  + $signed({7'd0, i_exp_carry});

  // No sticky bit exists, so an odd guard with an even LSB is an exact tie.
  assign round_up = i_norm_sum[1] & i_norm_sum[0];
  assign man_pre  = i_norm_sum[FP_MAN_W:1];
  assign man_ovf  = round_up & (man_pre == MAN_ALL_ONE);
  assign man_post = man_pre + {{(FP_MAN_W-1){1'b0}}, round_up};
  assign exp_post = man_ovf ? (exp_pre + 8'sd1) : exp_pre;

  always_comb begin
    o_word = '0;
    if (i_norm_sum == '0) begin
      o_word = '0;
    end else if (exp_pre <= 8'sd0) begin
      o_word = {i_sgn, {(FP_W-1){1'b0}}};
    end else if (exp_post >= 8'sd63) begin
      o_word = {i_sgn, EXP_SAT_VAL, MAN_ALL_ONE};
    end else begin
      o_word = {i_sgn, exp_post[FP_EXP_W-1:0], man_post};
    end
  end

endmodule

// File: rtl/mac_stg5.sv
// Final MAC stage: packs stage-4 results and buffers them in a small FIFO;
// o_inhibit stalls the whole upstream pipeline while the FIFO is full.
module mac_stg5
  import mac_stg5_pkg::*;
#(
  parameter int DEPTH = 4
)
(
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_valid,
  input  logic [NORM_W-1:0]     i_norm_sum,
  input  logic [EXP_DIFF_W-1:0] i_exp_diff,
  input  logic                  i_exp_carry,
  input  logic                  i_sgn,
  input  logic [FP_EXP_W-1:0]   i_max_exp,
  input  logic [Q_W-1:0]        i_Q_frac,
  input  logic                  i_ready,
  output logic                  o_valid,
  output logic [FP_W-1:0]       o_data,
  output logic [Q_W-1:0]        o_Q_frac,
  output logic                  o_inhibit
);

  localparam int AW = (DEPTH > 2) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0]   FULL_COUNT = (AW+1)'(DEPTH);
  localparam logic [AW:0]   CNT_ONE    = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE    = AW'(1);

  fifo_entry_t     mem [DEPTH];
  fifo_entry_t     head;
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [AW:0]     count;
  logic [FP_W-1:0] packed_word;
  logic            push;
  logic            pop;

  fp_pack_rne u_pack (
    .i_norm_sum  (i_norm_sum),
    .i_exp_diff  (i_exp_diff),
    .i_exp_carry (i_exp_carry),
    .i_sgn       (i_sgn),
    .i_max_exp   (i_max_exp),
    .o_word      (packed_word)
  );

  assign push = i_valid & ~o_inhibit;
  assign pop  = o_valid & i_ready;

  always_ff @(posedge i_clk) begin
    if (push) begin
      mem[wr_ptr] <= '{data: packed_word, q_frac: i_Q_frac};
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
      case ({push, pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

  assign head      = mem[rd_ptr];
  assign o_valid   = (count != '0);
  assign o_inhibit = (count == FULL_COUNT);
  assign o_data    = o_valid ? head.data   : '0;
  assign o_Q_frac  = o_valid ? head.q_frac : '0;

endmodule

// File: tb/tb_mac_stg5.sv
// Randomized and directed checks of mac_stg5 against a queue-based reference model.
module tb_mac_stg5;

  localparam int DEPTH = 4;

  typedef struct packed {
    logic [15:0] data;
    logic [4:0]  q;
  } exp_t;

  logic        i_clk = 1'b0;
  logic        i_rst = 1'b1;
  logic        i_valid = 1'b0;
  logic [10:0] i_norm_sum = '0;
  logic [4:0]  i_exp_diff = '0;
  logic        i_exp_carry = 1'b0;
  logic        i_sgn = 1'b0;
  logic [5:0]  i_max_exp = '0;
  logic [4:0]  i_Q_frac = '0;
  logic        i_ready = 1'b0;
  logic        o_valid;
  logic [15:0] o_data;
  logic [4:0]  o_Q_frac;
  logic        o_inhibit;

  int   vectors = 0;
  int   miscompares = 0;
  exp_t sb[$];

  mac_stg5 #(.DEPTH(DEPTH)) dut (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_valid     (i_valid),
    .i_norm_sum  (i_norm_sum),
    .i_exp_diff  (i_exp_diff),
    .i_exp_carry (i_exp_carry),
    .i_sgn       (i_sgn),
    .i_max_exp   (i_max_exp),
    .i_Q_frac    (i_Q_frac),
    .i_ready     (i_ready),
    .o_valid     (o_valid),
    .o_data      (o_data),
    .o_Q_frac    (o_Q_frac),
    .o_inhibit   (o_inhibit)
  );

  always #5 i_clk = ~i_clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectors++;
    if (observed !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // Reference packer: plain integer arithmetic on the numeric rules.
  function automatic logic [15:0] refPack(logic [10:0] norm, logic [4:0] diff, logic carry,
                                          logic sgn, logic [5:0] maxe);
    int e;
    int d;
    int man;
    d = diff[4] ? int'(diff) - 32 : int'(diff);
    e = int'(maxe) + d + int'(carry);
    if (norm == 11'd0) return 16'h0000;
    if (e <= 0) return {sgn, 15'd0};
    man = int'(norm[9:0]) / 2;
    if (norm[0] && norm[1]) man = man + 1;
    if (man == 512) begin
      man = 0;
      e = e + 1;
    end
    if (e >= 63) return {sgn, 6'd62, 9'h1FF};
    return {sgn, e[5:0], man[8:0]};
  endfunction

  task automatic checkModel();
    int sz;
    sz = sb.size();
    checkOutput("valid", {31'd0, o_valid}, {31'd0, sz != 0});
    checkOutput("inhibit", {31'd0, o_inhibit}, {31'd0, sz == DEPTH});
    if (sz != 0) begin
      checkOutput("data", {16'd0, o_data}, {16'd0, sb[0].data});
      checkOutput("qfrac", {27'd0, o_Q_frac}, {27'd0, sb[0].q});
    end else begin
      checkOutput("data_idle", {16'd0, o_data}, 32'd0);
      checkOutput("qfrac_idle", {27'd0, o_Q_frac}, 32'd0);
    end
  endtask

  // One cycle: drive, check the registered state mid-cycle, then advance the model.
  task automatic applyStimulus(input logic v, input logic [10:0] norm, input logic [4:0] diff,
                               input logic carry, input logic sgn, input logic [5:0] maxe,
                               input logic [4:0] q, input logic rdy);
    bit doPush;
    bit doPop;
    i_valid     = v;
    i_norm_sum  = norm;
    i_exp_diff  = diff;
    i_exp_carry = carry;
    i_sgn       = sgn;
    i_max_exp   = maxe;
    i_Q_frac    = q;
    i_ready     = rdy;
    @(negedge i_clk);
    checkModel();
    doPop  = (sb.size() != 0) && rdy;
    doPush = v && (sb.size() != DEPTH);
    if (doPop) void'(sb.pop_front());
    if (doPush) sb.push_back('{data: refPack(norm, diff, carry, sgn, maxe), q: q});
    @(posedge i_clk);
    #1;
  endtask

  task automatic doReset();
    i_rst   = 1'b1;
    i_valid = 1'($urandom_range(0, 1));
    @(posedge i_clk);
    #1;
    i_rst = 1'b0;
    sb.delete();
  endtask

  task automatic drain();
    for (int i = 0; i < DEPTH + 1; i++) applyStimulus(1'b0, 11'h400, 5'd0, 1'b0, 1'b0, 6'd31, 5'd0, 1'b1);
  endtask

  task automatic packCheck(input string tag, input logic [10:0] norm, input logic [4:0] diff,
                           input logic carry, input logic sgn, input logic [5:0] maxe,
                           input logic [15:0] expected);
    drain();
    applyStimulus(1'b1, norm, diff, carry, sgn, maxe, 5'd9, 1'b1);
    checkOutput({tag, "_valid"}, {31'd0, o_valid}, 32'd1);
    checkOutput(tag, {16'd0, o_data}, {16'd0, expected});
  endtask

  logic [10:0] randNorm;

  initial begin
    repeat (2) @(posedge i_clk);
    #1;
    i_rst = 1'b0;
    checkOutput("rst_valid", {31'd0, o_valid}, 32'd0);
    checkOutput("rst_inhibit", {31'd0, o_inhibit}, 32'd0);
    checkOutput("rst_data", {16'd0, o_data}, 32'd0);
    checkOutput("rst_qfrac", {27'd0, o_Q_frac}, 32'd0);

    packCheck("pack_basic", 11'h400, 5'd0, 1'b0, 1'b0, 6'd31, 16'h3E00);
    packCheck("pack_man_ovf", 11'h7FF, 5'd0, 1'b0, 1'b0, 6'd10, 16'h1600);
    packCheck("pack_tie_even", 11'h401, 5'd0, 1'b0, 1'b1, 6'd10, 16'h9400);
    packCheck("pack_round_up", 11'h403, 5'd0, 1'b0, 1'b0, 6'd10, 16'h1402);
    packCheck("pack_flush", 11'h400, 5'b11101, 1'b0, 1'b1, 6'd2, 16'h8000);
    packCheck("pack_zero", 11'h000, 5'd0, 1'b0, 1'b1, 6'd31, 16'h0000);
    packCheck("pack_sat", 11'h400, 5'd0, 1'b1, 1'b0, 6'd62, 16'h7DFF);
    packCheck("pack_exp62", 11'h400, 5'd0, 1'b0, 1'b0, 6'd62, 16'h7C00);

    // Backpressure: five inputs against a stalled consumer.
    drain();
    for (int i = 1; i <= 5; i++) begin
      applyStimulus(1'b1, 11'h500, 5'd0, 1'b0, 1'b0, 6'd20, 5'(i), 1'b0);
      if (i == 4) checkOutput("bp_inhibit_after4", {31'd0, o_inhibit}, 32'd1);
    end
    checkOutput("bp_inhibit_held", {31'd0, o_inhibit}, 32'd1);
    checkOutput("bp_head_tag", {27'd0, o_Q_frac}, 32'd1);
    applyStimulus(1'b1, 11'h500, 5'd0, 1'b0, 1'b0, 6'd20, 5'd5, 1'b1);
    checkOutput("bp_inhibit_release", {31'd0, o_inhibit}, 32'd0);
    checkOutput("bp_tag_after_pop", {27'd0, o_Q_frac}, 32'd2);
    applyStimulus(1'b1, 11'h500, 5'd0, 1'b0, 1'b0, 6'd20, 5'd5, 1'b0);
    checkOutput("bp_refull", {31'd0, o_inhibit}, 32'd1);
    for (int k = 2; k <= 5; k++) begin
      checkOutput("bp_drain_tag", {27'd0, o_Q_frac}, 32'(k));
      applyStimulus(1'b0, 11'h400, 5'd0, 1'b0, 1'b0, 6'd31, 5'd0, 1'b1);
    end
    checkOutput("bp_drained", {31'd0, o_valid}, 32'd0);

    // Reset with three entries buffered.
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 11'h600, 5'd1, 1'b0, 1'b1, 6'd15, 5'(20 + i), 1'b0);
    checkOutput("mid_valid", {31'd0, o_valid}, 32'd1);
    doReset();
    checkOutput("mid_rst_valid", {31'd0, o_valid}, 32'd0);
    checkOutput("mid_rst_inhibit", {31'd0, o_inhibit}, 32'd0);
    checkOutput("mid_rst_data", {16'd0, o_data}, 32'd0);
    applyStimulus(1'b1, 11'h400, 5'd0, 1'b0, 1'b0, 6'd31, 5'd7, 1'b0);
    checkOutput("post_rst_data", {16'd0, o_data}, 32'h3E00);
    checkOutput("post_rst_tag", {27'd0, o_Q_frac}, 32'd7);
    applyStimulus(1'b0, 11'h400, 5'd0, 1'b0, 1'b0, 6'd31, 5'd0, 1'b1);
    checkOutput("post_rst_alone", {31'd0, o_valid}, 32'd0);

    // Random traffic with occasional resets.
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(0, 99) == 0) begin
        doReset();
      end else begin
        randNorm = ($urandom_range(0, 7) == 0) ? 11'd0 : {1'b1, 10'($urandom)};
        applyStimulus(1'($urandom_range(0, 9) < 7), randNorm, 5'($urandom), 1'($urandom),
                      1'($urandom), 6'($urandom), 5'($urandom), 1'($urandom_range(0, 9) < 6));
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
